tt_um_seq_divider: RTL and testbench
====================================

// Module: tt_um_seq_divider
// PURPOSE
//  Sequential restoring divider: 8-bit dividend / 4-bit divisor -> 8-bit quotient, 4-bit remainder.
//  Inverse of the 4x4 combinational multiplier tile: a product read from that tile (0..225) divides
//  back into its factors. Tiny Tapeout user tile using the standard tt_um pinout.
//  Start/busy/done handshake; one quotient bit resolved per clock, MSB first.
// PARAMETERS
//  ZERO_Q   8'hFF  quotient reported on divide-by-zero
//  N_BITS   8      dividend width = iteration count (fixed by pinout; not for override)
// PORTS
//  clk      in   1  clock, all state on rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  ena      in   1  tile enable; 0 freezes all state (no capture, no iteration)
//  ui_in    in   8  dividend
//  uio_in   in   8  [3:0] divisor, [4] start, [5] sel; [7:6] ignored
//  uo_out   out  8  sel=0: quotient; sel=1: {err,3'b000,remainder[3:0]} (combinational mux of regs)
//  uio_out  out  8  [6] busy, [7] done; [5:0] driven 0
//  uio_oe   out  8  constant 8'b1100_0000
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, quotient=0, remainder=0, err=0, busy=0, done=0, count=0.
//  States: IDLE -> RUN -> DONE; DONE behaves as IDLE for start acceptance.
//  Accept: edge with ena=1, state in {IDLE,DONE}, start=1 -> latch dividend (ui_in) and divisor
//   (uio_in[3:0]), clear done, count=0. Divisor!=0 -> RUN (busy=1). Divisor==0 -> DONE next edge.
//  start is level-sampled: holding it high after DONE restarts a new division on that edge.
//  RUN, per edge (ena=1): partial remainder P (5 bits) = {P[3:0], dividend bit MSB-first};
//   if P >= divisor: P -= divisor, quotient bit = 1, else 0. count increments.
//  After 8th iteration: state=DONE, busy=0, done=1, quotient/remainder/err registers updated.
//  Latency: accept at edge N; done=1 visible after edge N+8; busy=1 visible after N..N+7.
//  Result registers change only at completion; prior result readable while busy.
//  done stays 1 until next accepted start; busy and done never both 1.
//  start while RUN: ignored, operands not re-latched, count unaffected.
//  Divisor 0: after edge N+1 done=1, quotient=ZERO_Q, remainder=0, err=1. err cleared by next
//   successful division.
//  Remainder always < divisor (fits 4 bits); quotient up to 255 (dividend/1).
//  ena=0 mid-RUN: hold count/partial state; resume on ena=1, total latency = 8 enabled edges.
//  Reset mid-RUN: immediate abort to reset values; no partial result exposed.
//  uio_in[3:0]/ui_in changes during RUN have no effect (operands latched).
// TESTING
//  ui=12, div=3, start 1 cycle -> busy 8 cycles, done=1, uo_out=4; sel=1 -> 8'h00.
//  ui=225, div=15 -> q=15 r=0; ui=200, div=7 -> q=28 r=4 (sel=1 -> 8'h04); ui=255, div=1 -> q=255 r=0.
//  div=0, ui=35 -> done after 1 edge, q=8'hFF, sel=1 -> 8'h80; next 35/5 -> q=7, err=0.
//  ui=35/div=5 started, at cycle 3 drive ui=0/div=1 with start=1 -> ignored, result q=7 r=0 at N+8.
//  start 100/9, drop rst_n at cycle 4 -> busy=0, done=0, uo_out=0 immediately; re-run -> q=11 r=1.
//  start 77/6, ena=0 for 5 cycles mid-RUN -> done at N+13, q=12 r=5; uio_oe=8'hC0 throughout.

Source files
------------

// File: rtl/tt_um_seq_divider.sv
// Sequential restoring divider tile: 8-bit dividend / 4-bit divisor.
// The FSM runs one quotient bit per enabled clock, MSB first. Results are
// published only when all eight bits are done, so the previous result stays
// readable while a new division is in progress.
module tt_um_seq_divider #(
  parameter logic [7:0] ZERO_Q = 8'hFF,
  parameter int         N_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAST_CNT = 4'(N_BITS - 1);

  // Pin decode; uio_in[7:6] are deliberately left unconnected.
  logic [3:0] div_in;
  logic       start;
  logic       sel;
  logic       unused_pins;

  assign div_in      = uio_in[3:0];
  assign start       = uio_in[4];
  assign sel         = uio_in[5];
  assign unused_pins = &{1'b0, uio_in[7:6]};

  // Working registers and published results.
  logic [1:0] state_q,  state_d;
  logic [7:0] dvd_q,    dvd_d;    // dividend, shifted left as bits are consumed
  logic [3:0] dvs_q,    dvs_d;    // latched divisor
  logic [3:0] prem_q,   prem_d;   // partial remainder (always < divisor)
  logic [7:0] qacc_q,   qacc_d;   // quotient bits collected so far
  logic [3:0] count_q,  count_d;
  logic [7:0] quo_q,    quo_d;
  logic [3:0] rem_q,    rem_d;
  logic       err_q,    err_d;

  // One restoring step: bring in the next dividend bit and try to subtract.
  logic [4:0] trial;
  logic [4:0] diff;
  logic       qbit;
  logic [3:0] prem_nxt;
  logic [7:0] qacc_nxt;

  assign trial    = {prem_q, dvd_q[7]};
  assign diff     = trial - {1'b0, dvs_q};
  assign qbit     = (trial >= {1'b0, dvs_q});
  assign prem_nxt = qbit ? diff[3:0] : trial[3:0];
  assign qacc_nxt = {qacc_q[6:0], qbit};

  logic busy;
  logic done;

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  // Next-state logic: start acceptance, iteration and result publication.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    qacc_d  = qacc_q;
    count_d = count_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;

    if (ena) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // start is level-sensitive: held high after DONE it restarts.
          if (start) begin
            state_d = S_RUN;
            dvd_d   = ui_in;
            dvs_d   = div_in;
            prem_d  = 4'd0;
            qacc_d  = 8'd0;
            count_d = 4'd0;
          end
        end
        S_RUN: begin
          if (dvs_q == 4'd0) begin
            // Divide-by-zero resolves on the first edge after acceptance.
            state_d = S_DONE;
            quo_d   = ZERO_Q;
            rem_d   = 4'd0;
            err_d   = 1'b1;
          end else begin
            dvd_d   = {dvd_q[6:0], 1'b0};
            prem_d  = prem_nxt;
            qacc_d  = qacc_nxt;
            count_d = count_q + 4'd1;
            if (count_q == LAST_CNT) begin
              state_d = S_DONE;
              quo_d   = qacc_nxt;
              rem_d   = prem_nxt;
              err_d   = 1'b0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      prem_q  <= 4'd0;
      qacc_q  <= 8'd0;
      count_q <= 4'd0;
      quo_q   <= 8'd0;
      rem_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      qacc_q  <= qacc_d;
      count_q <= count_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Output mux straight from the result registers.
  always_comb begin
    uo_out  = sel ? {err_q, 3'b000, rem_q} : quo_q;
    uio_out = {done, busy, 5'b00000, unused_pins & 1'b0};
    uio_oe  = 8'b1100_0000;
  end

endmodule

// File: tb/tb_tt_um_seq_divider.sv
// Scoreboard bench for the sequential divider: stimulus pushes expected
// results, a negedge monitor pops and checks them on each rising done.
module tb_tt_um_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [3:0] div;
  logic       start;
  logic       mon_sel;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Ignored pins [7:6] held high to show they do not matter.
  assign uio_in = {2'b11, mon_sel, start, div};

  tt_um_seq_divider dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  wire busy = uio_out[6];
  wire done = uio_out[7];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: owns the sel pin, reads both views of each new result.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_excl actual=11 required=not both");
      end
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=1 required=no result pending");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          mon_sel = 1'b0;
          #1;
          chk("quotient", uo_out, e.q);
          mon_sel = 1'b1;
          #1;
          chk("rem_err", uo_out, {e.err, 3'b000, e.r});
          mon_sel = 1'b0;
          chk("latency", cyc - e.acc, e.lat);
        end
      end
      prev_done = done;
    end
  end

  // Drive one start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] eq, input logic [3:0] er,
                       input logic eerr, input int elat);
    exp_t e;
    @(negedge clk);
    ui_in = a;
    div   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.q = eq; e.r = er; e.err = eerr; e.lat = elat; e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done) return;
      @(negedge clk);
    end
    errors++;
    $display("FAIL done_timeout actual=0 required=1");
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'd0; div = 4'd0; start = 1'b0; mon_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_uo_out",  uo_out,  8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe",  uio_oe,  8'hC0);
    rst_n = 1'b1;

    // 12/3 with busy tracked through all eight iterations.
    issue(8'd12, 4'd3, 8'd4, 4'd0, 1'b0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("busy_run", {busy, done}, 2'b10);
      if (i < 7) @(negedge clk);
    end
    @(negedge clk);
    wait_done();

    issue(8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 8); wait_done();
    issue(8'd200, 4'd7,  8'd28, 4'd4, 1'b0, 8); wait_done();
    issue(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8); wait_done();

    // Divide by zero, then a normal division clears err.
    issue(8'd35, 4'd0, 8'hFF, 4'd0, 1'b1, 1); wait_done();
    issue(8'd35, 4'd5, 8'd7,  4'd0, 1'b0, 8); wait_done();

    // Start during RUN with new operands is ignored.
    issue(8'd35, 4'd5, 8'd7, 4'd0, 1'b0, 8);
    @(negedge clk);
    @(negedge clk);
    ui_in = 8'd0; div = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset mid-run aborts everything.
    issue(8'd100, 4'd9, 8'd11, 4'd1, 1'b0, 8);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_uio_out", uio_out, 8'h00);
    chk("abort_uo_out",  uo_out,  8'h00);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd100, 4'd9, 8'd11, 4'd1, 1'b0, 8); wait_done();

    // ena low for five edges stretches latency to 13.
    issue(8'd77, 4'd6, 8'd12, 4'd5, 1'b0, 13);
    @(negedge clk);
    @(negedge clk);
    ena = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("ena_hold_busy", {busy, done}, 2'b10);
      chk("uio_oe_const",  uio_oe, 8'hC0);
    end
    ena = 1'b1;
    wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
